// File: rtl/mmap_out_regs.sv
// Memory-mapped output peripheral at 0xc000-0xc004.
// It holds the LED, seven-segment value/control and countdown timer registers,
// drives the board outputs, and answers read-back on the shared tri-state bus.
module mmap_out_regs #(
    parameter int TICK_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mm_we,
    input  logic        mm_re,
    input  logic [15:0] addr,
    inout  wire  [15:0] databus,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        timer_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);

    localparam logic [15:0] ADDR_LED   = 16'hc000;
    localparam logic [15:0] ADDR_HEX   = 16'hc001;
    localparam logic [15:0] ADDR_CTRL  = 16'hc002;
    localparam logic [15:0] ADDR_LOAD  = 16'hc003;
    localparam logic [15:0] ADDR_STAT  = 16'hc004;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [9:0]      led;
    logic [15:0]     hex_val;
    logic [4:0]      hex_ctrl;
    logic [15:0]     count;
    logic [PW-1:0]   prescale;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic            done;
    logic            running;
    logic            blank_all;
    logic            bus_drive;
    logic [15:0]     rdata;

    logic wr_led, wr_hex, wr_ctrl, load_wr, abort_wr, rd_stat;

    assign wr_led   = mm_we && (addr == ADDR_LED);
    assign wr_hex   = mm_we && (addr == ADDR_HEX);
    assign wr_ctrl  = mm_we && (addr == ADDR_CTRL);
    assign load_wr  = mm_we && (addr == ADDR_LOAD);
    assign abort_wr = mm_we && (addr == ADDR_STAT) && databus[0];
    assign rd_stat  = mm_re && (addr == ADDR_STAT);
    assign running  = (state == S_RUN);
    assign LEDR     = led;

    // Standard active-low {g,f,e,d,c,b,a} hexadecimal digit decode.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // CPU-writable display registers; unused data bits are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led      <= '0;
            hex_val  <= '0;
            hex_ctrl <= 5'h0F;
        end else begin
            if (wr_led)  led      <= databus[9:0];
            if (wr_hex)  hex_val  <= databus;
            if (wr_ctrl) hex_ctrl <= databus[4:0];
        end
    end

    // Free-running blink divider; only reset restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Countdown FSM: a load beats expiry, an abort beats the tick, DONE waits for a status read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            prescale  <= '0;
            done      <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= 1'b0;
            if (load_wr) begin
                prescale <= '0;
                count    <= databus;
                if (databus != 16'd0) begin
                    done  <= 1'b0;
                    state <= S_RUN;
                end else begin
                    done      <= 1'b1;
                    state     <= S_DONE;
                    timer_irq <= 1'b1;
                end
            end else if (abort_wr) begin
                done  <= 1'b0;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_RUN: begin
                        if (prescale == PS_LAST) begin
                            prescale <= '0;
                            if (count <= 16'd1) begin
                                count     <= '0;
                                done      <= 1'b1;
                                state     <= S_DONE;
                                timer_irq <= 1'b1;
                            end else begin
                                count <= count - 16'd1;
                            end
                        end else begin
                            prescale <= prescale + 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (rd_stat) begin
                            done  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read-back mux, valid in the same cycle as the read strobe.
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_LED:  rdata = {6'b0, led};
            ADDR_HEX:  rdata = hex_val;
            ADDR_CTRL: rdata = {11'b0, hex_ctrl};
            ADDR_LOAD: rdata = count;
            ADDR_STAT: rdata = {14'b0, running, done};
            default:   rdata = '0;
        endcase
    end

    assign bus_drive = mm_re && !mm_we && (addr >= ADDR_LED) && (addr <= ADDR_STAT);
    assign databus   = bus_drive ? rdata : 16'hzzzz;

    // Digit decode with per-digit enable and a global blink blank.
    always_comb begin
        blank_all = hex_ctrl[4] && blink_phase;
        HEX0 = (blank_all || !hex_ctrl[0]) ? 7'h7F : seg7(hex_val[3:0]);
        HEX1 = (blank_all || !hex_ctrl[1]) ? 7'h7F : seg7(hex_val[7:4]);
        HEX2 = (blank_all || !hex_ctrl[2]) ? 7'h7F : seg7(hex_val[11:8]);
        HEX3 = (blank_all || !hex_ctrl[3]) ? 7'h7F : seg7(hex_val[15:12]);
    end

endmodule

// File: tb/tb_mmap_out_regs.sv
// Bench for mmap_out_regs: stimulus tasks queue expected responses from a
// cycle-arithmetic model; a negedge monitor pops and compares them.
module tb_mmap_out_regs;

    localparam int T = 3;
    localparam int B = 4;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [15:0] ADDRS [8] = '{16'hc000, 16'hc001, 16'hc002, 16'hc003,
                                          16'hc004, 16'hc00b, 16'hc010, 16'hc016};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mm_we = 1'b0;
    logic        mm_re = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] tb_data = '0;
    logic        tb_drive = 1'b0;
    tri1  [15:0] bus;
    logic [9:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic        timer_irq;

    assign bus = tb_drive ? tb_data : 16'hzzzz;

    mmap_out_regs #(.TICK_DIV(T), .BLINK_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .mm_we(mm_we), .mm_re(mm_re), .addr(addr),
        .databus(bus), .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Edges since reset release.
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          kind;
        int          tag;
        logic [15:0] exp;
    } item_t;

    item_t chk_q[$];
    int    irq_q[$];
    int    total = 0;
    int    bad = 0;
    string NAMES [6] = '{"bus", "LEDR", "HEX0", "HEX1", "HEX2", "HEX3"};

    // Reference model state.
    logic [9:0]  m_led;
    logic [15:0] m_hv;
    logic [4:0]  m_ctrl;
    bit          m_run, m_done;
    int          m_L, m_N;
    logic [15:0] m_hold;

    task automatic model_reset();
        m_led = '0; m_hv = '0; m_ctrl = 5'h0F;
        m_run = 0; m_done = 0; m_L = 0; m_N = 0; m_hold = '0;
    endtask

    function automatic void settle();
        if (m_run && cyc >= m_L + m_N * T) begin
            m_run = 0; m_done = 1; m_hold = '0;
        end
    endfunction

    function automatic logic [15:0] cur_count();
        settle();
        if (m_run) return 16'(m_N - (cyc - m_L) / T);
        return m_hold;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        logic [15:0] c;
        c = cur_count();
        case (a)
            16'hc000: return {6'b0, m_led};
            16'hc001: return m_hv;
            16'hc002: return {11'b0, m_ctrl};
            16'hc003: return c;
            16'hc004: return {14'b0, m_run, m_done};
            default:  return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [6:0] ref_hex(input int i);
        logic [3:0] nib;
        nib = m_hv[i*4 +: 4];
        if (!m_ctrl[i] || (m_ctrl[4] && ((cyc / B) % 2 == 1))) return 7'h7F;
        return SEG[nib];
    endfunction

    task automatic push(input int k, input logic [15:0] e);
        item_t it;
        it.kind = k; it.tag = cyc; it.exp = e;
        chk_q.push_back(it);
    endtask

    task automatic chk_disp();
        push(1, {6'b0, m_led});
        for (int i = 0; i < 4; i++) push(2 + i, {9'b0, ref_hex(i)});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drop_irq(input int e);
        while (irq_q.size() > 0 && irq_q[irq_q.size()-1] >= e) void'(irq_q.pop_back());
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit re = 0);
        logic [15:0] pre_cnt;
        int e;
        pre_cnt = cur_count();
        addr = a; tb_data = d; tb_drive = 1; mm_we = 1; mm_re = re;
        @(posedge clk); #1;
        e = cyc;
        mm_we = 0; mm_re = 0; tb_drive = 0;
        case (a)
            16'hc000: m_led = d[9:0];
            16'hc001: m_hv = d;
            16'hc002: m_ctrl = d[4:0];
            16'hc003: begin
                drop_irq(e);
                if (d != 0) begin
                    m_run = 1; m_done = 0; m_L = e; m_N = int'(d);
                    irq_q.push_back(e + int'(d) * T);
                end else begin
                    m_run = 0; m_done = 1; m_hold = '0;
                    irq_q.push_back(e);
                end
            end
            16'hc004: if (d[0]) begin
                drop_irq(e);
                m_hold = pre_cnt; m_run = 0; m_done = 0;
            end
            default: ;
        endcase
    endtask

    task automatic rd(input logic [15:0] a);
        logic [15:0] e;
        bit done_pre;
        e = ref_read(a);
        done_pre = m_done;
        push(0, e);
        addr = a; mm_re = 1;
        @(posedge clk); #1;
        mm_re = 0;
        if (a == 16'hc004 && done_pre) m_done = 0;
    endtask

    task automatic chk_hiz(input logic [15:0] a);
        addr = a;
        push(0, 16'hFFFF);
        idle(1);
    endtask

    // Monitor: compare queued expectations and irq pulses on the falling edge.
    item_t       mon_it;
    logic [15:0] mon_act;
    initial begin
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0 && chk_q[0].tag <= cyc) begin
                mon_it = chk_q.pop_front();
                case (mon_it.kind)
                    0:       mon_act = bus;
                    1:       mon_act = {6'b0, LEDR};
                    2:       mon_act = {9'b0, HEX0};
                    3:       mon_act = {9'b0, HEX1};
                    4:       mon_act = {9'b0, HEX2};
                    default: mon_act = {9'b0, HEX3};
                endcase
                total++;
                if (mon_act !== mon_it.exp) begin
                    bad++;
                    $display("FAIL %s addr=%h: got %h expected %h (cycle %0d)",
                             NAMES[mon_it.kind], addr, mon_act, mon_it.exp, cyc);
                end
            end
            if (timer_irq) begin
                total++;
                if (irq_q.size() > 0 && irq_q[0] == cyc) begin
                    void'(irq_q.pop_front());
                end else begin
                    bad++;
                    $display("FAIL timer_irq: got 1 expected 0 (cycle %0d)", cyc);
                end
            end else if (irq_q.size() > 0 && irq_q[0] <= cyc) begin
                total++;
                bad++;
                $display("FAIL timer_irq: got 0 expected 1 at cycle %0d (now %0d)", irq_q[0], cyc);
                void'(irq_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        int r;
        logic [15:0] a;
        logic [15:0] d;
        model_reset();
        idle(3);
        rst_n = 1;

        // Reset state and undriven bus.
        chk_disp();
        rd(16'hc002);
        rd(16'hc003);
        chk_hiz(16'hc000);
        rd(16'hc010);
        rd(16'hc00b);

        // LED and hex value writes.
        wr(16'hc000, 16'hFFFF);
        wr(16'hc001, 16'h9A3F);
        chk_disp();
        rd(16'hc000);
        rd(16'hc001);
        wr(16'hc000, 16'h02AA, 1);
        chk_disp();
        rd(16'hc000);

        // Digit enables and blink.
        wr(16'hc002, 16'h0015);
        for (int i = 0; i < 12; i++) begin
            chk_disp();
            idle(1);
        end
        rd(16'hc002);
        wr(16'hc002, 16'h000F);

        // Countdown of 2 ticks, then status read clears done.
        wr(16'hc003, 16'd2);
        for (k = 0; k < 40 && cyc < m_L + 2 * T; k++) idle(1);
        rd(16'hc004);
        rd(16'hc004);
        rd(16'hc003);

        // Abort mid-count.
        wr(16'hc003, 16'd5);
        idle(3);
        wr(16'hc004, 16'h0001);
        rd(16'hc004);
        rd(16'hc003);
        idle(20);

        // Reload on the expiry edge.
        wr(16'hc003, 16'd1);
        idle(2);
        wr(16'hc003, 16'd2);
        rd(16'hc004);
        for (k = 0; k < 40 && cyc <= m_L + 2 * T; k++) idle(1);
        rd(16'hc004);
        rd(16'hc004);

        // Status read in the expiry cycle does not clear done.
        wr(16'hc003, 16'd1);
        idle(2);
        rd(16'hc004);
        rd(16'hc004);
        rd(16'hc004);

        // Zero load expires at once.
        wr(16'hc003, 16'd0);
        rd(16'hc004);
        rd(16'hc004);

        // Asynchronous reset mid-run.
        wr(16'hc000, 16'h0155);
        wr(16'hc001, 16'h1234);
        wr(16'hc003, 16'd4);
        idle(2);
        rst_n = 0;
        irq_q.delete();
        model_reset();
        #1;
        chk_disp();
        rd(16'hc003);
        rd(16'hc004);
        rst_n = 1;
        chk_disp();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            a = ADDRS[$urandom_range(0, 7)];
            if (r <= 4) begin
                d = 16'($urandom);
                if (a == 16'hc003) d = 16'($urandom_range(0, 4));
                wr(a, d);
                chk_disp();
            end else if (r <= 7) begin
                rd(a);
            end else if (r == 8) begin
                idle($urandom_range(1, 8));
            end else begin
                chk_disp();
                idle(1);
            end
        end

        for (k = 0; k < 200 && irq_q.size() > 0; k++) idle(1);
        if (irq_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending irq expectations, expected 0", irq_q.size());
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
